adc_spi_cfg_master: RTL and testbench

Parametrised SPI configuration master for the board's high-speed ADCs (AD9231-class, 3-wire SPI, 16-bit instruction header). It runs a complete write or read transaction of 1 to MAX_BYTES data bytes on a single start pulse and generates SCLK/CSB. It drives SDIO with a separate output-enable for the pad tristate and returns read data with a done pulse. It sits between the configuration sequencer and the ADC pins, and is generalised in divider, byte count and read capability.

---
 rtl/adc_spi_cfg_master_pkg.sv | 22 ++
 rtl/adc_spi_cfg_master_if.sv | 31 +++
 rtl/adc_spi_cfg_master_sclk_gen.sv | 36 +++
 rtl/adc_spi_cfg_master.sv | 153 +++++++++++++++
 tb/tb_adc_spi_cfg_master.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_cfg_master_pkg.sv
// Shared constants for the ADC SPI configuration master: one-hot FSM encoding
// and the 16-bit instruction header layout {rw, nbytes_m1, addr[12:0]}.
package adc_spi_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_IDLE     = 5'b00001;
  localparam logic [STATE_W-1:0] ST_CS_SETUP = 5'b00010;
  localparam logic [STATE_W-1:0] ST_HEADER   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_DATA     = 5'b01000;
  localparam logic [STATE_W-1:0] ST_CS_HOLD  = 5'b10000;

  localparam int HDR_W      = 16;
  localparam int HDR_ADDR_W = 13;

  function automatic logic [HDR_W-1:0] make_header(input logic                  rw,
                                                   input logic [1:0]            nbytes_m1,
                                                   input logic [HDR_ADDR_W-1:0] addr13);
    return {rw, nbytes_m1, addr13};
  endfunction

endpackage

// File: rtl/adc_spi_cfg_master_if.sv
// Request/response bus between the configuration sequencer (master) and the
// SPI configuration master block (slave), plus the FSM state for observation.
interface adc_spi_cfg_master_if
  import adc_spi_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int MAX_BYTES = 4
);
  // Handshake: start is a one-cycle request taken only while busy=0 and not in
  // the done cycle; busy stays high until the cycle done pulses, when it drops.
  logic                   start;
  logic                   rw;
  logic [1:0]             nbytes_m1;
  logic [ADDR_W-1:0]      addr;
  logic [8*MAX_BYTES-1:0] wdata;
  logic                   busy;
  logic                   done;
  logic [8*MAX_BYTES-1:0] rdata;
  logic [STATE_W-1:0]     dbg_state;

  modport master (
    output start, rw, nbytes_m1, addr, wdata,
    input  busy, done, rdata, dbg_state
  );

  modport slave (
    input  start, rw, nbytes_m1, addr, wdata,
    output busy, done, rdata, dbg_state
  );

endinterface

// File: rtl/adc_spi_cfg_master_sclk_gen.sv
// SCLK phase generator: low for the first half of each CLK_DIV-cycle bit period,
// with last-phase (bit_end) and 3/4-period (sample) strobes; idles high when disabled.
module adc_spi_sclk_gen #(
  parameter int CLK_DIV = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic bit_end_o,
  output logic sample_o
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF   = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'((3 * CLK_DIV) / 4);

  logic [PH_W-1:0] phase_q, phase_d;

  // Held at zero while disabled so the first enabled cycle is phase 0 (falling edge).
  always_comb begin
    phase_d = '0;
    if (en_i && (phase_q != PH_LAST)) phase_d = phase_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign sclk_o    = !en_i || (phase_q >= PH_HALF);
  assign bit_end_o = en_i && (phase_q == PH_LAST);
  assign sample_o  = en_i && (phase_q == PH_SAMPLE);

endmodule

// File: rtl/adc_spi_cfg_master.sv
// 3-wire SPI configuration master for AD9231-class ADCs: 16-bit header plus 1..MAX_BYTES
// data bytes per start pulse. Read support is built only with ADC_SPI_READBACK_EN defined.
module adc_spi_cfg_master
  import adc_spi_pkg::*;
#(
  parameter int CLK_DIV   = 200,
  parameter int ADDR_W    = 13,
  parameter int MAX_BYTES = 4
) (
  input  logic                  clk_200m,
  input  logic                  rst_n,
  adc_spi_cfg_master_if.slave   cfg,
  output logic                  spi_sclk,
  output logic                  spi_csb,
  output logic                  spi_sdio_o,
  output logic                  spi_sdio_oe,
  input  logic                  spi_sdio_i
);

  localparam int HALF   = CLK_DIV / 2;
  localparam int DATA_W = 8 * MAX_BYTES;
  localparam int SH_W   = HDR_W + DATA_W;
  localparam int CNT_W  = $clog2(SH_W);
  localparam int TMR_W  = $clog2(HALF);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(HALF - 1);
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   bit_cnt_q;
  logic [CNT_W-1:0]   bit_last;
  logic [1:0]         nb_q;
  logic [SH_W-1:0]    sh_q;
  logic               done_q;

  logic               accept;
  logic               shifting;
  logic               hold_exit;
  logic               bit_end;
  logic               sample;
  logic               rw_eff;
  logic [HDR_ADDR_W-1:0] addr13;
  logic [DATA_W-1:0]  wdata_al;

  // Header address field is exactly 13 bits whatever the bus width.
  if (ADDR_W >= HDR_ADDR_W) begin : g_addr_trunc
    assign addr13 = cfg.addr[HDR_ADDR_W-1:0];
  end else begin : g_addr_ext
    assign addr13 = {{(HDR_ADDR_W-ADDR_W){1'b0}}, cfg.addr};
  end

`ifdef ADC_SPI_READBACK_EN
  assign rw_eff = cfg.rw;
`else
  assign rw_eff = 1'b0;
`endif

  // First data byte is the highest used lane; left-align it behind the header.
  assign wdata_al = cfg.wdata << (8 * (MAX_BYTES - 1 - int'(cfg.nbytes_m1)));

  assign accept    = (state_q == ST_IDLE) && cfg.start && !done_q;
  assign shifting  = (state_q == ST_HEADER) || (state_q == ST_DATA);
  assign hold_exit = (state_q == ST_CS_HOLD) && (tmr_q == TMR_LAST);
  assign bit_last  = CNT_W'(HDR_W + 8 * int'(nb_q) + 7);

  adc_spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk_200m),
    .rst_n     (rst_n),
    .en_i      (shifting),
    .sclk_o    (spi_sclk),
    .bit_end_o (bit_end),
    .sample_o  (sample)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_CS_SETUP;
      ST_CS_SETUP: if (tmr_q == TMR_LAST) state_d = ST_HEADER;
      ST_HEADER:   if (bit_end && (bit_cnt_q == HDR_LAST)) state_d = ST_DATA;
      ST_DATA:     if (bit_end && (bit_cnt_q == bit_last)) state_d = ST_CS_HOLD;
      ST_CS_HOLD:  if (tmr_q == TMR_LAST) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_d = '0;
    if (((state_q == ST_CS_SETUP) || (state_q == ST_CS_HOLD)) && (tmr_q != TMR_LAST))
      tmr_d = tmr_q + 1'b1;
  end

  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_cnt_q <= '0;
      nb_q      <= '0;
      sh_q      <= '1;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      done_q  <= hold_exit;
      if (accept) begin
        bit_cnt_q <= '0;
        nb_q      <= cfg.nbytes_m1;
        sh_q      <= {make_header(rw_eff, cfg.nbytes_m1, addr13), wdata_al};
      end else if (bit_end) begin
        bit_cnt_q <= bit_cnt_q + 1'b1;
        sh_q      <= {sh_q[SH_W-2:0], 1'b1};
      end
    end
  end

`ifdef ADC_SPI_READBACK_EN
  logic              rw_q;
  logic [DATA_W-1:0] rx_q;
  logic [DATA_W-1:0] rdata_q;

  // rx_q is cleared per transaction so lanes above the last byte read back as 0.
  always_ff @(posedge clk_200m or negedge rst_n) begin
    if (!rst_n) begin
      rw_q    <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        rw_q <= cfg.rw;
        rx_q <= '0;
      end else if (rw_q && (state_q == ST_DATA) && sample) begin
        rx_q <= {rx_q[DATA_W-2:0], spi_sdio_i};
      end
      if (rw_q && hold_exit) rdata_q <= rx_q;
    end
  end

  assign spi_sdio_oe = !(rw_q && (state_q == ST_DATA));
  assign cfg.rdata   = rdata_q;
`else
  logic unused_rb;
  assign unused_rb   = ^{cfg.rw, spi_sdio_i, sample};
  assign spi_sdio_oe = 1'b1;
  assign cfg.rdata   = '0;
`endif

  assign spi_csb       = (state_q == ST_IDLE);
  assign spi_sdio_o    = shifting ? sh_q[SH_W-1] : 1'b1;
  assign cfg.busy      = (state_q != ST_IDLE);
  assign cfg.done      = done_q;
  assign cfg.dbg_state = state_q;

endmodule

// File: tb/tb_adc_spi_cfg_master.sv
// Directed bench for adc_spi_cfg_master at CLK_DIV=8 with a 3-wire SPI device model;
// read expectations follow the ADC_SPI_READBACK_EN build setting.
module tb_adc_spi_cfg_master;
  import adc_spi_pkg::*;

  localparam int CLK_DIV   = 8;
  localparam int ADDR_W    = 13;
  localparam int MAX_BYTES = 4;
  localparam int BUDGET    = 2000;
`ifdef ADC_SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk_200m = 1'b0;
  logic rst_n    = 1'b0;
  always #5 clk_200m = ~clk_200m;

  logic spi_sclk, spi_csb, spi_sdio_o, spi_sdio_oe;
  logic spi_sdio_i = 1'b0;

  adc_spi_cfg_master_if #(.ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) cfg();

  adc_spi_cfg_master #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W), .MAX_BYTES(MAX_BYTES)) dut (
    .clk_200m    (clk_200m),
    .rst_n       (rst_n),
    .cfg         (cfg),
    .spi_sclk    (spi_sclk),
    .spi_csb     (spi_csb),
    .spi_sdio_o  (spi_sdio_o),
    .spi_sdio_oe (spi_sdio_oe),
    .spi_sdio_i  (spi_sdio_i)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- monitors and device model ----------------
  int          rise_cnt    = 0;
  int          csb_low_cyc = 0;
  int          oe_low_cyc  = 0;
  int          done_cnt    = 0;
  logic [63:0] mosi_bits   = '0;
  int          rise_base   = 0;
  logic [31:0] model_word  = '0;
  int          model_n     = 0;

  always @(posedge spi_sclk) begin
    mosi_bits = {mosi_bits[62:0], spi_sdio_o};
    rise_cnt++;
  end

  always @(negedge clk_200m) begin
    if (!spi_csb)     csb_low_cyc++;
    if (!spi_sdio_oe) oe_low_cyc++;
    if (cfg.done)     done_cnt++;
  end

  // Device drives read data on SCLK falling edges after the 16 header bits.
  always @(negedge spi_sclk) begin : device_model
    int k;
    k = rise_cnt - rise_base - HDR_W;
    if (k >= 0 && k < 8 * model_n) spi_sdio_i = model_word[8*model_n-1-k];
  end

  // ---------------- driver ----------------
  int          r_rise, r_csb, r_oe, done0;
  logic [15:0] r_hdr;
  logic [31:0] r_data;

  task automatic run_xfer(input logic rw_i, input logic [1:0] nb_i, input logic [12:0] addr_i,
                          input logic [31:0] wd_i, input bit inject);
    int csb0, oe0, n8;
    bit got_done;
    @(posedge clk_200m); #1;
    rise_base = rise_cnt; csb0 = csb_low_cyc; oe0 = oe_low_cyc; done0 = done_cnt;
    cfg.start = 1'b1; cfg.rw = rw_i; cfg.nbytes_m1 = nb_i; cfg.addr = addr_i; cfg.wdata = wd_i;
    @(posedge clk_200m); #1;
    cfg.start = 1'b0;
    @(negedge clk_200m);
    vectors++;
    if ({spi_csb, cfg.busy} !== 2'b01) begin
      miscompares++; $display("FAIL csb_fall {csb,busy} got=%b exp=01", {spi_csb, cfg.busy});
    end
    got_done = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (inject && (i == 40 || i == 150)) begin
        cfg.start = 1'b1; cfg.rw = 1'b1; cfg.nbytes_m1 = 2'd3; cfg.addr = 13'h1FFF;
      end else begin
        cfg.start = 1'b0;
      end
      @(negedge clk_200m);
      if (cfg.done) begin got_done = 1'b1; break; end
    end
    cfg.start = 1'b0;
    vectors++;
    if (!got_done) begin
      miscompares++; $display("FAIL done_timeout got=none exp=done within %0d cycles", BUDGET);
    end
    vectors++;
    if ({spi_csb, cfg.busy} !== 2'b10) begin
      miscompares++; $display("FAIL done_cycle {csb,busy} got=%b exp=10", {spi_csb, cfg.busy});
    end
    n8     = 8 * (int'(nb_i) + 1);
    r_rise = rise_cnt - rise_base;
    r_csb  = csb_low_cyc - csb0;
    r_oe   = oe_low_cyc - oe0;
    r_hdr  = 16'(mosi_bits >> n8);
    r_data = 32'(mosi_bits & ((64'd1 << n8) - 64'd1));
  endtask

  task automatic settle();
    repeat (5) @(negedge clk_200m);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cfg.start = 1'b0; cfg.rw = 1'b0; cfg.nbytes_m1 = '0; cfg.addr = '0; cfg.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_200m);
    vectors++;
    if ({spi_sclk, spi_csb, spi_sdio_o, spi_sdio_oe, cfg.busy, cfg.done} !== 6'b111100) begin
      miscompares++; $display("FAIL rst_outputs got=%b exp=111100",
                              {spi_sclk, spi_csb, spi_sdio_o, spi_sdio_oe, cfg.busy, cfg.done});
    end
    vectors++;
    if (cfg.rdata !== 32'h0) begin
      miscompares++; $display("FAIL rst_rdata got=%h exp=00000000", cfg.rdata);
    end
    vectors++;
    if (cfg.dbg_state !== ST_IDLE) begin
      miscompares++; $display("FAIL rst_state got=%b exp=%b", cfg.dbg_state, ST_IDLE);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk_200m);
    vectors++;
    if ({spi_csb, cfg.busy, cfg.done} !== 3'b100) begin
      miscompares++; $display("FAIL post_rst_idle got=%b exp=100", {spi_csb, cfg.busy, cfg.done});
    end
  endtask

  task automatic test_single_write();
    run_xfer(1'b0, 2'd0, 13'h014, 32'h0000_0005, 1'b0);
    settle();
    vectors++; if (r_rise !== 24) begin miscompares++; $display("FAIL sw_rise got=%0d exp=24", r_rise); end
    vectors++; if (r_hdr !== 16'h0014) begin miscompares++; $display("FAIL sw_hdr got=%h exp=0014", r_hdr); end
    vectors++; if (r_data !== 32'h05) begin miscompares++; $display("FAIL sw_data got=%h exp=05", r_data); end
    vectors++; if (r_csb !== 200) begin miscompares++; $display("FAIL sw_csb_low got=%0d exp=200", r_csb); end
    vectors++; if (r_oe !== 0) begin miscompares++; $display("FAIL sw_oe_low got=%0d exp=0", r_oe); end
    vectors++;
    if (done_cnt - done0 !== 1) begin
      miscompares++; $display("FAIL sw_done_cnt got=%0d exp=1", done_cnt - done0);
    end
  endtask

  task automatic test_four_byte_write();
    run_xfer(1'b0, 2'd3, 13'h0FF, 32'h1122_3344, 1'b0);
    settle();
    vectors++; if (r_rise !== 48) begin miscompares++; $display("FAIL w4_rise got=%0d exp=48", r_rise); end
    vectors++; if (r_hdr !== 16'h60FF) begin miscompares++; $display("FAIL w4_hdr got=%h exp=60ff", r_hdr); end
    vectors++;
    if (r_data !== 32'h1122_3344) begin miscompares++; $display("FAIL w4_data got=%h exp=11223344", r_data); end
    vectors++; if (r_csb !== 392) begin miscompares++; $display("FAIL w4_csb_low got=%0d exp=392", r_csb); end
  endtask

  task automatic test_read();
    model_word = 32'h0000_1234; model_n = 2;
    run_xfer(1'b1, 2'd1, 13'h001, 32'h0, 1'b0);
    settle();
    vectors++;
    if (r_hdr !== (RB ? 16'hA001 : 16'h2001)) begin
      miscompares++; $display("FAIL rd2_hdr got=%h exp=%h", r_hdr, RB ? 16'hA001 : 16'h2001);
    end
    vectors++;
    if (cfg.rdata !== (RB ? 32'h0000_1234 : 32'h0)) begin
      miscompares++; $display("FAIL rd2_rdata got=%h exp=%h", cfg.rdata, RB ? 32'h0000_1234 : 32'h0);
    end
    vectors++;
    if (r_oe !== (RB ? 128 : 0)) begin
      miscompares++; $display("FAIL rd2_oe_low got=%0d exp=%0d", r_oe, RB ? 128 : 0);
    end
    model_word = 32'h0000_00A5; model_n = 1;
    run_xfer(1'b1, 2'd0, 13'h001, 32'h0, 1'b0);
    settle();
    vectors++;
    if (r_hdr !== (RB ? 16'h8001 : 16'h0001)) begin
      miscompares++; $display("FAIL rd1_hdr got=%h exp=%h", r_hdr, RB ? 16'h8001 : 16'h0001);
    end
    vectors++;
    if (cfg.rdata !== (RB ? 32'h0000_00A5 : 32'h0)) begin
      miscompares++; $display("FAIL rd1_rdata got=%h exp=%h", cfg.rdata, RB ? 32'h0000_00A5 : 32'h0);
    end
    vectors++;
    if (r_oe !== (RB ? 64 : 0)) begin
      miscompares++; $display("FAIL rd1_oe_low got=%0d exp=%0d", r_oe, RB ? 64 : 0);
    end
    model_n = 0;
    run_xfer(1'b0, 2'd0, 13'h002, 32'h0000_0077, 1'b0);
    settle();
    vectors++;
    if (cfg.rdata !== (RB ? 32'h0000_00A5 : 32'h0)) begin
      miscompares++; $display("FAIL rdata_hold got=%h exp=%h", cfg.rdata, RB ? 32'h0000_00A5 : 32'h0);
    end
    vectors++; if (r_oe !== 0) begin miscompares++; $display("FAIL wr_after_rd_oe got=%0d exp=0", r_oe); end
  endtask

  task automatic test_start_while_busy();
    run_xfer(1'b0, 2'd0, 13'h033, 32'h0000_009C, 1'b1);
    settle();
    vectors++; if (r_rise !== 24) begin miscompares++; $display("FAIL busy_rise got=%0d exp=24", r_rise); end
    vectors++; if (r_hdr !== 16'h0033) begin miscompares++; $display("FAIL busy_hdr got=%h exp=0033", r_hdr); end
    vectors++; if (r_data !== 32'h9C) begin miscompares++; $display("FAIL busy_data got=%h exp=9c", r_data); end
    vectors++;
    if ({done_cnt - done0, 1'b0} !== {1, 1'b0} || cfg.busy !== 1'b0) begin
      miscompares++; $display("FAIL busy_single_done done=%0d busy=%b exp done=1 busy=0",
                              done_cnt - done0, cfg.busy);
    end
  endtask

  task automatic test_back_to_back();
    int d_start;
    d_start = done_cnt;
    run_xfer(1'b0, 2'd0, 13'h010, 32'h0000_00AA, 1'b0);
    vectors++; if (r_hdr !== 16'h0010) begin miscompares++; $display("FAIL b2b_hdr0 got=%h exp=0010", r_hdr); end
    run_xfer(1'b0, 2'd1, 13'h011, 32'h0000_BBCC, 1'b0);
    settle();
    vectors++; if (r_hdr !== 16'h2011) begin miscompares++; $display("FAIL b2b_hdr1 got=%h exp=2011", r_hdr); end
    vectors++; if (r_data !== 32'hBBCC) begin miscompares++; $display("FAIL b2b_data1 got=%h exp=bbcc", r_data); end
    vectors++; if (r_csb !== 264) begin miscompares++; $display("FAIL b2b_csb_low got=%0d exp=264", r_csb); end
    vectors++;
    if (done_cnt - d_start !== 2) begin
      miscompares++; $display("FAIL b2b_done_cnt got=%0d exp=2", done_cnt - d_start);
    end
  endtask

  task automatic test_reset_mid();
    int  d_mid;
    bit  reached;
    @(posedge clk_200m); #1;
    rise_base = rise_cnt;
    cfg.start = 1'b1; cfg.rw = 1'b0; cfg.nbytes_m1 = 2'd0; cfg.addr = 13'h055; cfg.wdata = 32'h5A;
    @(posedge clk_200m); #1;
    cfg.start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      @(negedge clk_200m);
      if (cfg.dbg_state === ST_DATA && (rise_cnt - rise_base) == 19 && spi_sclk === 1'b0) begin
        reached = 1'b1; break;
      end
    end
    vectors++;
    if (!reached) begin miscompares++; $display("FAIL mid_reach got=none exp=DATA bit 3"); end
    d_mid = done_cnt;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({spi_sclk, spi_csb, spi_sdio_o, spi_sdio_oe, cfg.busy, cfg.done} !== 6'b111100) begin
      miscompares++; $display("FAIL mid_rst_outputs got=%b exp=111100",
                              {spi_sclk, spi_csb, spi_sdio_o, spi_sdio_oe, cfg.busy, cfg.done});
    end
    vectors++;
    if (cfg.rdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst_rdata got=%h exp=0", cfg.rdata); end
    repeat (4) @(negedge clk_200m);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_200m);
    vectors++;
    if (done_cnt - d_mid !== 0) begin
      miscompares++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - d_mid);
    end
    run_xfer(1'b0, 2'd0, 13'h0AB, 32'h0000_003C, 1'b0);
    settle();
    vectors++; if (r_hdr !== 16'h00AB) begin miscompares++; $display("FAIL post_mid_hdr got=%h exp=00ab", r_hdr); end
    vectors++; if (r_data !== 32'h3C) begin miscompares++; $display("FAIL post_mid_data got=%h exp=3c", r_data); end
    vectors++; if (r_csb !== 200) begin miscompares++; $display("FAIL post_mid_csb got=%0d exp=200", r_csb); end
    vectors++;
    if (done_cnt - done0 !== 1) begin
      miscompares++; $display("FAIL post_mid_done got=%0d exp=1", done_cnt - done0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_four_byte_write();
    test_read();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished by 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
